// File: rtl/sdram_disp_rd_sched.sv
// Display read scheduler: streams one frame of RGB565 words from the bank the camera is not writing into the display FIFO.
// Latency: 2-cycle FIFO clear after frame_start, then one CHECK cycle before each rd_req; a single request is outstanding at a time.
// Backpressure: waits in CHECK until the FIFO has room for a burst and holds rd_req until rd_ack; RD_TIMEOUT_EN adds a REQ/WAIT watchdog.
module sdram_disp_rd_sched #(
    parameter int                FIFO_DEPTH  = 1024,
    parameter int                BURST_LEN   = 256,
    parameter int                FRAME_WORDS = 307200,
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BANK1_BASE  = 24'h100000,
    parameter int                TIMEOUT_CYC = 4096
) (
    input  logic              sdram_clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              wr_bank,
    input  logic [10:0]       fifo_wrusedw,
    output logic              fifo_aclr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [8:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic              active_bank,
    output logic              frame_busy
`ifdef RD_TIMEOUT_EN
    ,
    output logic              err_timeout
`endif
);

    typedef enum logic [2:0] {IDLE, CLEAR, CHECK, REQ, WAIT, DONE} state_t;

    localparam int               CNT_W     = $clog2(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [10:0]      FILL_MAX  = 11'(FIFO_DEPTH - BURST_LEN);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] remaining;
    logic             clr_cnt;
    logic             restart_pend;
    logic             go_clear, burst_done, load_len, frame_end, set_pend, wd_trip;

`ifdef RD_TIMEOUT_EN
    localparam logic [12:0] WD_LAST = 13'(TIMEOUT_CYC - 1);
    logic [12:0] wdog;
`endif

    assign remaining = FRAME_CNT - issued;
    assign fifo_aclr = (state == CLEAR);
    assign rd_req    = (state == REQ);

    always_comb begin
        state_nxt  = state;
        go_clear   = 1'b0;
        burst_done = 1'b0;
        load_len   = 1'b0;
        frame_end  = 1'b0;
        set_pend   = 1'b0;
        wd_trip    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (frame_start) go_clear = 1'b1;
            end
            CLEAR: begin
                if (clr_cnt) state_nxt = CHECK;
            end
            CHECK: begin
                if (frame_start) begin
                    go_clear = 1'b1;
                end else if (remaining == '0) begin
                    frame_end = 1'b1;
                    state_nxt = DONE;
                end else if (fifo_wrusedw <= FILL_MAX) begin
                    load_len  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                set_pend = frame_start;
                // ack and done together complete the whole burst in one step
                if (rd_ack && rd_done) burst_done = 1'b1;
                else if (rd_ack)       state_nxt  = WAIT;
            end
            WAIT: begin
                set_pend = frame_start;
                if (rd_done) burst_done = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (burst_done) begin
            if (restart_pend || frame_start) go_clear = 1'b1;
            else                             state_nxt = CHECK;
        end
        if (go_clear) state_nxt = CLEAR;
`ifdef RD_TIMEOUT_EN
        if ((state == REQ || state == WAIT) && state_nxt == state && wdog == WD_LAST) begin
            wd_trip   = 1'b1;
            state_nxt = DONE;
        end
`endif
    end

    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_addr      <= '0;
            rd_len       <= '0;
            active_bank  <= 1'b0;
            frame_busy   <= 1'b0;
            issued       <= '0;
            clr_cnt      <= 1'b0;
            restart_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (go_clear) begin
                // display the bank the camera is not filling
                active_bank  <= ~wr_bank;
                rd_addr      <= wr_bank ? '0 : BANK1_BASE;
                issued       <= '0;
                frame_busy   <= 1'b1;
                restart_pend <= 1'b0;
                clr_cnt      <= 1'b0;
            end else begin
                if (state == CLEAR) clr_cnt <= 1'b1;
                if (set_pend)       restart_pend <= 1'b1;
                if (load_len)
                    rd_len <= (remaining >= BURST_CNT) ? 9'(BURST_LEN) : 9'(remaining);
                if (burst_done) begin
                    rd_addr <= rd_addr + ADDR_W'(rd_len);
                    issued  <= issued + CNT_W'(rd_len);
                end
                if (frame_end) frame_busy <= 1'b0;
                if (wd_trip) begin
                    frame_busy   <= 1'b0;
                    restart_pend <= 1'b0;
                end
            end
        end
    end

`ifdef RD_TIMEOUT_EN
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog        <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state_nxt != state)                 wdog <= '0;
            else if (state == REQ || state == WAIT) wdog <= wdog + 13'd1;
            if (wd_trip) err_timeout <= 1'b1;
        end
    end
`endif

endmodule
